nd_2to1: RTL and testbench

Two-input, one-output merge stage for link-protocol channels: it takes messages from two upstream links (typically the two outputs of a 1-to-2 splitter or two independent producers), arbitrates round-robin, and forwards each message, data unchanged, on a single outgoing link. It holds one message of storage and acknowledges an input as soon as its data is latched, so the upstream link is released while the downstream link is still busy. Every link uses the team's two-phase toggle handshake: `req`, `ack` and `dat` per channel.

---
 rtl/nd_2to1_if.sv | 30 +++
 rtl/nd_2to1.sv | 123 ++++++++++++
 tb/tb_nd_2to1.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nd_2to1_if.sv
// Link bundle for the nd_2to1 merge stage: two toggle-handshake inputs and one output.
// slave = the merge block's view, master = the surrounding producers/consumer.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

interface nd_2to1_if #(
  parameter int DSZ = `DATA_SIZE
);
  logic           i_rcv0_req;
  logic [DSZ-1:0] i_rcv0_dat;
  logic           o_rcv0_ack;
  logic           i_rcv1_req;
  logic [DSZ-1:0] i_rcv1_dat;
  logic           o_rcv1_ack;
  logic           o_snd0_req;
  logic [DSZ-1:0] o_snd0_dat;
  logic           o_snd0_src;
  logic           i_snd0_ack;

  modport slave (
    input  i_rcv0_req, i_rcv0_dat, i_rcv1_req, i_rcv1_dat, i_snd0_ack,
    output o_rcv0_ack, o_rcv1_ack, o_snd0_req, o_snd0_dat, o_snd0_src
  );

  modport master (
    output i_rcv0_req, i_rcv0_dat, i_rcv1_req, i_rcv1_dat, i_snd0_ack,
    input  o_rcv0_ack, o_rcv1_ack, o_snd0_req, o_snd0_dat, o_snd0_src
  );
endinterface

// File: rtl/nd_2to1.sv
// Round-robin 2-to-1 merge of two-phase toggle links with one message of storage.
// Define ND_2TO1_SYNC_EN to pass incoming req/ack through 2-flop synchronizers.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module nd_2to1 #(
  parameter int ASZ = `ADDRESS_SIZE,
  parameter int DSZ = `DATA_SIZE
) (
  input  logic     i_clk,
  input  logic     i_reset,
  nd_2to1_if.slave link
);

  // ASZ only exists for link compatibility; reject nonsensical widths at elaboration.
  if (ASZ < 1 || DSZ < 1) begin : g_param_chk
    $error("nd_2to1: ASZ and DSZ must be positive");
  end

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  logic req0_s, req1_s, ack_s;

`ifdef ND_2TO1_SYNC_EN
  logic [1:0] r_req0_sync, r_req1_sync, r_ack_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req0_sync <= '0;
      r_req1_sync <= '0;
      r_ack_sync  <= '0;
    end else begin
      r_req0_sync <= {r_req0_sync[0], link.i_rcv0_req};
      r_req1_sync <= {r_req1_sync[0], link.i_rcv1_req};
      r_ack_sync  <= {r_ack_sync[0],  link.i_snd0_ack};
    end
  end

  assign req0_s = r_req0_sync[1];
  assign req1_s = r_req1_sync[1];
  assign ack_s  = r_ack_sync[1];
`else
  assign req0_s = link.i_rcv0_req;
  assign req1_s = link.i_rcv1_req;
  assign ack_s  = link.i_snd0_ack;
`endif

  state_t         r_state, nxt_state;
  logic           r_last, nxt_last;
  logic           r_snd_req, nxt_snd_req;
  logic [DSZ-1:0] r_snd_dat, nxt_snd_dat;
  logic           r_snd_src, nxt_snd_src;
  logic           r_ack0, nxt_ack0;
  logic           r_ack1, nxt_ack1;

  logic pend0, pend1, win;

  assign pend0 = req0_s ^ r_ack0;
  assign pend1 = req1_s ^ r_ack1;
  // Input 1 wins when it is alone, or on a tie when input 0 was served last.
  assign win   = (pend0 && pend1) ? ~r_last : pend1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_snd_req <= 1'b0;
      r_snd_dat <= '0;
      r_snd_src <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
    end else begin
      r_state   <= nxt_state;
      r_last    <= nxt_last;
      r_snd_req <= nxt_snd_req;
      r_snd_dat <= nxt_snd_dat;
      r_snd_src <= nxt_snd_src;
      r_ack0    <= nxt_ack0;
      r_ack1    <= nxt_ack1;
    end
  end

  always_comb begin
    nxt_state   = r_state;
    nxt_last    = r_last;
    nxt_snd_req = r_snd_req;
    nxt_snd_dat = r_snd_dat;
    nxt_snd_src = r_snd_src;
    nxt_ack0    = r_ack0;
    nxt_ack1    = r_ack1;
    unique case (r_state)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          nxt_snd_dat = win ? link.i_rcv1_dat : link.i_rcv0_dat;
          nxt_snd_src = win;
          nxt_snd_req = ~r_snd_req;
          if (win) nxt_ack1 = ~r_ack1;
          else     nxt_ack0 = ~r_ack0;
          nxt_last    = win;
          nxt_state   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack_s == r_snd_req) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign link.o_rcv0_ack = r_ack0;
  assign link.o_rcv1_ack = r_ack1;
  assign link.o_snd0_req = r_snd_req;
  assign link.o_snd0_dat = r_snd_dat;
  assign link.o_snd0_src = r_snd_src;

endmodule

// File: tb/tb_nd_2to1.sv
// Directed bench for nd_2to1 (default build): message-count model checked every cycle,
// plus literal expectations on reset, arbitration order and back-pressure.
module tb_nd_2to1;
  localparam int DSZ = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nd_2to1_if #(.DSZ(DSZ)) link ();

  nd_2to1 #(.ASZ(8), .DSZ(DSZ)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .link    (link)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream producers and downstream consumer, all driven on the falling edge.
  int msg0 [256];
  int msg1 [256];
  int w0 = 0, w1 = 0;
  int r0 = 0, r1 = 0;
  bit auto_ack = 1'b0;
  int kick_req = 0, kick_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      link.i_rcv0_req = 1'b0;
      link.i_rcv1_req = 1'b0;
      link.i_snd0_ack = 1'b0;
      link.i_rcv0_dat = '0;
      link.i_rcv1_dat = '0;
    end else begin
      if (r0 != w0 && link.i_rcv0_req == link.o_rcv0_ack) begin
        link.i_rcv0_dat = DSZ'(msg0[r0]);
        link.i_rcv0_req = ~link.i_rcv0_req;
        r0++;
      end
      if (r1 != w1 && link.i_rcv1_req == link.o_rcv1_ack) begin
        link.i_rcv1_dat = DSZ'(msg1[r1]);
        link.i_rcv1_req = ~link.i_rcv1_req;
        r1++;
      end
      if (kick_req != kick_done) begin
        link.i_snd0_ack = ~link.i_snd0_ack;
        kick_done = kick_req;
      end else if (auto_ack && link.o_snd0_req != link.i_snd0_ack) begin
        link.i_snd0_ack = link.o_snd0_req;
      end
    end
  end

  // Model: counts of messages served per input and forwarded; phases are count parity.
  int  m_served0 = 0, m_served1 = 0, m_sent = 0;
  bit  m_busy = 1'b0, m_last = 1'b1;
  int  m_dat = 0;
  int  m_src = 0;
  int  log_dat[$];
  int  log_src[$];
  bit  prev_req = 1'b0;

  initial begin
    bit was_rst, p0, p1, g;
    forever begin
      @(posedge clk);
      was_rst = rst;
      if (rst) begin
        m_served0 = 0; m_served1 = 0; m_sent = 0;
        m_busy = 1'b0; m_last = 1'b1; m_dat = 0; m_src = 0;
      end else if (m_busy) begin
        if (link.i_snd0_ack == m_sent[0]) m_busy = 1'b0;
      end else begin
        p0 = (link.i_rcv0_req != m_served0[0]);
        p1 = (link.i_rcv1_req != m_served1[0]);
        if (p0 || p1) begin
          g = (p0 && p1) ? !m_last : p1;
          m_dat = g ? int'(link.i_rcv1_dat) : int'(link.i_rcv0_dat);
          m_src = int'(g);
          if (g) m_served1++;
          else   m_served0++;
          m_sent++;
          m_last = g;
          m_busy = 1'b1;
        end
      end
      #1;
      chk("snd_req", int'(link.o_snd0_req), m_sent & 1);
      chk("rcv0_ack", int'(link.o_rcv0_ack), m_served0 & 1);
      chk("rcv1_ack", int'(link.o_rcv1_ack), m_served1 & 1);
      chk("snd_dat", int'(link.o_snd0_dat), m_dat);
      chk("snd_src", int'(link.o_snd0_src), m_src);
      if (!was_rst && link.o_snd0_req != prev_req) begin
        log_dat.push_back(int'(link.o_snd0_dat));
        log_src.push_back(int'(link.o_snd0_src));
      end
      prev_req = link.o_snd0_req;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push0(input int v);
    msg0[w0] = v;
    w0++;
  endtask

  task automatic push1(input int v);
    msg1[w1] = v;
    w1++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_snd_req", int'(link.o_snd0_req), 0);
    chk("rst_snd_dat", int'(link.o_snd0_dat), 0);
    chk("rst_snd_src", int'(link.o_snd0_src), 0);
    chk("rst_rcv0_ack", int'(link.o_rcv0_ack), 0);
    chk("rst_rcv1_ack", int'(link.o_rcv1_ack), 0);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < 300) begin
      @(posedge clk);
      #3;
      done = (r0 == w0) && (r1 == w1) &&
             (link.i_rcv0_req == link.o_rcv0_ack) &&
             (link.i_rcv1_req == link.o_rcv1_ack) &&
             (link.o_snd0_req == link.i_snd0_ack);
      c++;
    end
    chk({name, "_drain"}, int'(done), 1);
  endtask

  task automatic chk_log(input string name, input int idx, input int d, input int s);
    chk({name, "_present"}, int'(log_dat.size() > idx), 1);
    if (log_dat.size() > idx) begin
      chk({name, "_dat"}, log_dat[idx], d);
      chk({name, "_src"}, log_src[idx], s);
    end
  endtask

  initial begin
    int base;
    do_reset();

    // Single message on input 0, held until acknowledged.
    base = log_dat.size();
    push0(5);
    @(posedge clk);
    #1;
    chk("t1_dat", int'(link.o_snd0_dat), 5);
    chk("t1_src", int'(link.o_snd0_src), 0);
    chk("t1_req", int'(link.o_snd0_req), 1);
    chk("t1_ack0", int'(link.o_rcv0_ack), 1);
    chk("t1_ack1", int'(link.o_rcv1_ack), 0);
    #1 auto_ack = 1'b1;
    drain("t1");
    chk("t1_count", log_dat.size() - base, 1);

    // Simultaneous first requests after reset: input 0 wins the tie.
    do_reset();
    base = log_dat.size();
    push0(5);
    push1(2);
    drain("t2");
    chk_log("t2_first", base, 5, 0);
    chk_log("t2_second", base + 1, 2, 1);

    // Sustained contention alternates strictly.
    do_reset();
    base = log_dat.size();
    for (int i = 0; i < 8; i++) begin
      push0(i);
      push1(10 + i);
    end
    drain("t3");
    chk("t3_count", log_dat.size() - base, 16);
    for (int k = 0; k < 16; k++)
      chk_log($sformatf("t3_msg%0d", k), base + k, (k % 2 == 0) ? k / 2 : 10 + k / 2, k % 2);

    // Back-pressure: output held, input 1 pending but not acknowledged.
    auto_ack = 1'b0;
    base = log_dat.size();
    push0(20);
    tick(3);
    push1(21);
    tick(1);
    chk("t4_req1_pending", int'(link.i_rcv1_req), 1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t4_ack1_held", int'(link.o_rcv1_ack), 0);
      chk("t4_dat_held", int'(link.o_snd0_dat), 20);
    end
    auto_ack = 1'b1;
    drain("t4");
    chk_log("t4_first", base, 20, 0);
    chk_log("t4_second", base + 1, 21, 1);

    // Reset while a message is in flight, then normal service.
    auto_ack = 1'b0;
    push0(30);
    tick(3);
    do_reset();
    base = log_dat.size();
    push1(40);
    auto_ack = 1'b1;
    drain("t5");
    chk_log("t5_after_rst", base, 40, 1);

    // Stray output ack toggle while idle must not lock the block up.
    auto_ack = 1'b0;
    kick_req++;
    tick(2);
    base = log_dat.size();
    push0(50);
    tick(3);
    auto_ack = 1'b1;
    drain("t6");
    chk_log("t6_stray_ack", base, 50, 0);
    push1(51);
    drain("t6b");
    chk_log("t6_next", base + 1, 51, 1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
